mac_result_sign_restorer: RTL and testbench

- Back end of the sign-magnitude MAC path. The front-end negator turns signed operands into magnitudes before the unsigned multiplier array.
- This block takes the unsigned products from that array and re-applies each product's sign using a configurable two's-complement chain (single/dual/quad). It then optionally accumulates.
- Sign flags are captured at operand-issue time and queued in a small FIFO. This decouples them from the multiplier latency.

---
 rtl/mac_result_sign_restorer.sv | 166 ++++++++++++++++
 tb/tb_mac_result_sign_restorer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_sign_restorer.sv
// Sign-restore back end of the sign-magnitude MAC: queues product sign flags,
// re-negates unsigned products per lane group and optionally accumulates.
module mac_result_sign_restorer #(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
    parameter int MAC_ACC_WIDTH  = 2 * MAC_MULT_WIDTH,
    parameter int SGN_FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [MAC_CONF_WIDTH-1:0]     cfg,
    input  logic                          sgn_valid,
    output logic                          sgn_ready,
    input  logic                          A0B0_neg,
    input  logic                          A1B1_neg,
    input  logic                          A2B2_neg,
    input  logic                          A3B3_neg,
    input  logic                          prod_valid,
    input  logic [4*MAC_MULT_WIDTH-1:0]   prod_in,
    input  logic                          acc_clr,
    output logic                          res_valid,
    output logic [4*MAC_ACC_WIDTH-1:0]    res_out,
    output logic                          sgn_underflow
);

    localparam int LANES = 4;
    localparam int RES_W = LANES * MAC_ACC_WIDTH;
    localparam int PTR_W = $clog2(SGN_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {MODE_SINGLE, MODE_DUAL, MODE_QUAD} mode_t;

    // Segmented adder: the carry restarts with inj[i] wherever start[i] marks a group boundary.
    function automatic logic [RES_W-1:0] seg_add(input logic [RES_W-1:0] a,
                                                 input logic [RES_W-1:0] b,
                                                 input logic [LANES-1:0] start,
                                                 input logic [LANES-1:0] inj);
        logic [RES_W-1:0]       sum;
        logic                   carry;
        logic [MAC_ACC_WIDTH:0] s;
        sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (start[i]) carry = inj[i];
            s = {1'b0, a[i*MAC_ACC_WIDTH +: MAC_ACC_WIDTH]}
              + {1'b0, b[i*MAC_ACC_WIDTH +: MAC_ACC_WIDTH]}
              + {{MAC_ACC_WIDTH{1'b0}}, carry};
            sum[i*MAC_ACC_WIDTH +: MAC_ACC_WIDTH] = s[MAC_ACC_WIDTH-1:0];
            carry = s[MAC_ACC_WIDTH];
        end
        return sum;
    endfunction

    logic [LANES-1:0] mem [SGN_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, empty, push, pop, pop_req;
    logic [LANES-1:0] sgn_in, pop_sgn;

    mode_t            mode;
    logic [LANES-1:0] group_start, neg_seg;
    logic [RES_W-1:0] ext, inv, restored, acc_sum;

    logic             s1_valid, s1_clr;
    logic [RES_W-1:0] s1_val, acc;

    assign sgn_in  = {A3B3_neg, A2B2_neg, A1B1_neg, A0B0_neg};
    assign full    = (count == CNT_W'(SGN_FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop_req = en & prod_valid;
    assign pop     = pop_req & ~empty;
    // A full FIFO still takes a push when a pop frees the slot in the same cycle.
    assign sgn_ready = ~full | pop_req;
    assign push    = en & sgn_valid & sgn_ready;
    assign pop_sgn = mem[rd_ptr];

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        mode        = MODE_SINGLE;
        group_start = 4'b1111;
        ext         = '0;
        neg_seg     = pop_sgn;
        case (cfg[1:0])
            2'b01: begin
                mode        = MODE_DUAL;
                group_start = 4'b0101;
                ext[0 +: MAC_ACC_WIDTH]               = prod_in[0 +: MAC_ACC_WIDTH];
                ext[2*MAC_ACC_WIDTH +: MAC_ACC_WIDTH] = prod_in[MAC_ACC_WIDTH +: MAC_ACC_WIDTH];
                neg_seg = {{2{pop_sgn[3]}}, {2{pop_sgn[1]}}};
            end
            2'b10: begin
                mode        = MODE_QUAD;
                group_start = 4'b0001;
                ext[0 +: LANES*MAC_MULT_WIDTH] = prod_in;
                neg_seg = {LANES{pop_sgn[3]}};
            end
            default: begin
                for (int i = 0; i < LANES; i++)
                    ext[i*MAC_ACC_WIDTH +: MAC_ACC_WIDTH] =
                        MAC_ACC_WIDTH'(prod_in[i*MAC_MULT_WIDTH +: MAC_MULT_WIDTH]);
            end
        endcase
        if (!cfg[3]) neg_seg = '0;
        for (int i = 0; i < LANES; i++)
            inv[i*MAC_ACC_WIDTH +: MAC_ACC_WIDTH] =
                ext[i*MAC_ACC_WIDTH +: MAC_ACC_WIDTH] ^ {MAC_ACC_WIDTH{neg_seg[i]}};
        // ~x + 1: the +1 enters only at the base segment of each negated group.
        restored = seg_add(inv, '0, group_start, neg_seg & group_start);
        acc_sum  = seg_add(s1_clr ? '0 : acc, s1_val, group_start, '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            sgn_underflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop_req && empty) sgn_underflow <= 1'b1;
        end
    end

    // NOTE: the flag storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sgn_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_clr    <= 1'b0;
            s1_val    <= '0;
            res_valid <= 1'b0;
            res_out   <= '0;
            acc       <= '0;
        end else if (en) begin
            s1_valid  <= pop;
            if (pop) begin
                s1_val <= restored;
                s1_clr <= acc_clr;
            end
            res_valid <= s1_valid;
            if (s1_valid) begin
                if (cfg[2]) begin
                    acc     <= acc_sum;
                    res_out <= acc_sum;
                end else begin
                    res_out <= s1_val;
                end
            end
        end else begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_result_sign_restorer.sv
// Directed bench for mac_result_sign_restorer: arithmetic reference model
// checked on every cycle plus hand-computed literal results.
module tb_mac_result_sign_restorer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b1;
    logic [3:0]   cfg = 4'b0000;
    logic         sgn_valid = 1'b0;
    logic         sgn_ready;
    logic         A0B0_neg = 1'b0, A1B1_neg = 1'b0, A2B2_neg = 1'b0, A3B3_neg = 1'b0;
    logic         prod_valid = 1'b0;
    logic [63:0]  prod_in = '0;
    logic         acc_clr = 1'b0;
    logic         res_valid;
    logic [127:0] res_out;
    logic         sgn_underflow;

    mac_result_sign_restorer dut (
        .clk(clk), .rst(rst), .en(en), .cfg(cfg),
        .sgn_valid(sgn_valid), .sgn_ready(sgn_ready),
        .A0B0_neg(A0B0_neg), .A1B1_neg(A1B1_neg), .A2B2_neg(A2B2_neg), .A3B3_neg(A3B3_neg),
        .prod_valid(prod_valid), .prod_in(prod_in), .acc_clr(acc_clr),
        .res_valid(res_valid), .res_out(res_out), .sgn_underflow(sgn_underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [127:0] val;
        int           due;
    } res_t;

    logic [3:0]   m_fifo[$];
    res_t         m_res[$];
    logic [127:0] m_acc;
    int           m_ecnt;
    bit           m_uf;
    bit           exp_rv;
    logic [127:0] exp_res;

    function automatic logic [127:0] model_restore(input logic [63:0] p, input logic [3:0] f,
                                                   input logic [3:0] c);
        logic [127:0] r;
        logic [31:0]  v32;
        logic [63:0]  v64;
        r = '0;
        case (c[1:0])
            2'b01: for (int g = 0; g < 2; g++) begin
                v64 = {32'h0, p[g*32 +: 32]};
                if (c[3] && f[2*g+1]) v64 = -v64;
                r[g*64 +: 64] = v64;
            end
            2'b10: begin
                r = {64'h0, p};
                if (c[3] && f[3]) r = -r;
            end
            default: for (int i = 0; i < 4; i++) begin
                v32 = {16'h0, p[i*16 +: 16]};
                if (c[3] && f[i]) v32 = -v32;
                r[i*32 +: 32] = v32;
            end
        endcase
        return r;
    endfunction

    function automatic logic [127:0] model_add(input logic [127:0] a, input logic [127:0] b,
                                               input logic [3:0] c);
        logic [127:0] r;
        r = '0;
        case (c[1:0])
            2'b01:   for (int g = 0; g < 2; g++) r[g*64 +: 64] = a[g*64 +: 64] + b[g*64 +: 64];
            2'b10:   r = a + b;
            default: for (int i = 0; i < 4; i++) r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_res.delete();
        m_acc   = '0;
        m_ecnt  = 0;
        m_uf    = 1'b0;
        exp_rv  = 1'b0;
        exp_res = '0;
    endtask

    // Applies one clock edge worth of behaviour to the model using the inputs held at that edge.
    task automatic model_tick();
        int           pre;
        bit           do_pop;
        logic [3:0]   f;
        logic [127:0] v;
        res_t         e;
        exp_rv = 1'b0;
        if (en) begin
            m_ecnt++;
            if (m_res.size() > 0 && m_res[0].due == m_ecnt) begin
                exp_rv  = 1'b1;
                exp_res = m_res[0].val;
                void'(m_res.pop_front());
            end
            pre    = m_fifo.size();
            do_pop = prod_valid && pre > 0;
            if (prod_valid && pre == 0) m_uf = 1'b1;
            if (do_pop) begin
                f = m_fifo.pop_front();
                v = model_restore(prod_in, f, cfg);
                if (cfg[2]) begin
                    m_acc = model_add(acc_clr ? 128'h0 : m_acc, v, cfg);
                    v     = m_acc;
                end
                e.val = v;
                e.due = m_ecnt + 1;
                m_res.push_back(e);
            end
            if (sgn_valid && (pre < 4 || do_pop))
                m_fifo.push_back({A3B3_neg, A2B2_neg, A1B1_neg, A0B0_neg});
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("res_valid", 128'(res_valid), 128'(exp_rv));
            if (exp_rv) check("res_out", res_out, exp_res);
            check("sgn_ready", 128'(sgn_ready), 128'((m_fifo.size() < 4) || (en && prod_valid)));
            check("sgn_underflow", 128'(sgn_underflow), 128'(m_uf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic cyc(input bit sv, input logic [3:0] f, input bit pv,
                       input logic [63:0] p, input bit clr);
        sgn_valid  = sv;
        {A3B3_neg, A2B2_neg, A1B1_neg, A0B0_neg} = f;
        prod_valid = pv;
        prod_in    = p;
        acc_clr    = clr;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0, 64'h0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset res_valid", 128'(res_valid), 128'h0);
        check("reset res_out", res_out, 128'h0);
        check("reset sgn_ready", 128'(sgn_ready), 128'h1);
        check("reset sgn_underflow", 128'(sgn_underflow), 128'h0);
        rst = 1'b1;
        idle(1);

        // single signed multiply
        cfg = 4'b1000;
        cyc(1'b1, 4'b0001, 1'b0, 64'h0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 64'h0000_0000_0006_0006, 1'b0);
        idle(1);
        check("single res_valid", 128'(res_valid), 128'h1);
        check("single seg0", 128'(res_out[31:0]), 128'hFFFF_FFFA);
        check("single seg1", 128'(res_out[63:32]), 128'h0000_0006);
        idle(1);
        check("single pulse width", 128'(res_valid), 128'h0);

        // negating zero in lane 0 must not carry into segment 1
        cyc(1'b1, 4'b0001, 1'b0, 64'h0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 64'h0000_0000_0007_0000, 1'b0);
        idle(1);
        check("single carry cut", res_out, 128'h0000_0000_0000_0000_0000_0007_0000_0000);
        idle(1);

        // dual multiply
        cfg = 4'b1001;
        cyc(1'b1, 4'b0010, 1'b0, 64'h0, 1'b0);
        cyc(1'b1, 4'b1010, 1'b1, 64'h0001_0002_0000_0100, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 64'h0001_0002_0000_0100, 1'b0);
        check("dual literal", res_out, 128'h0000_0000_0001_0002_FFFF_FFFF_FFFF_FF00);
        idle(2);

        // unsigned: flags ignored
        cfg = 4'b0000;
        cyc(1'b1, 4'b1111, 1'b0, 64'h0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 64'h0000_0000_0000_FFFF, 1'b0);
        idle(1);
        check("unsigned literal", res_out, 128'h0000_FFFF);
        idle(1);

        // quad multiply-accumulate
        cfg = 4'b1110;
        repeat (3) cyc(1'b1, 4'b1000, 1'b0, 64'h0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 64'h5, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1, 64'h5, 1'b0);
        check("quad mac -5", res_out, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFB);
        cyc(1'b0, 4'b0000, 1'b1, 64'h5, 1'b0);
        check("quad mac -10", res_out, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF6);
        idle(1);
        check("quad mac -15", res_out, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
        idle(1);

        // single mac: segment wraps to zero without carrying into its neighbour
        cfg = 4'b1100;
        cyc(1'b1, 4'b0001, 1'b0, 64'h0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0, 64'h0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 64'h1, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1, 64'h1, 1'b0);
        idle(1);
        check("single mac wrap", res_out, 128'h0);
        idle(1);

        // FIFO full, held push, simultaneous push/pop, drain, underflow
        cfg = 4'b1000;
        cyc(1'b1, 4'b0001, 1'b0, 64'h0, 1'b0);
        cyc(1'b1, 4'b0010, 1'b0, 64'h0, 1'b0);
        cyc(1'b1, 4'b0100, 1'b0, 64'h0, 1'b0);
        cyc(1'b1, 4'b1000, 1'b0, 64'h0, 1'b0);
        check("fifo full ready", 128'(sgn_ready), 128'h0);
        cyc(1'b1, 4'b1111, 1'b0, 64'h0, 1'b0);
        check("fifo held push ready", 128'(sgn_ready), 128'h0);
        cyc(1'b1, 4'b0011, 1'b1, 64'h0004_0003_0002_0001, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0, 64'h0, 1'b0);
        check("fifo push+pop keeps full", 128'(sgn_ready), 128'h0);
        cyc(1'b0, 4'b0000, 1'b1, 64'h0008_0007_0006_0005, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 64'h000C_000B_000A_0009, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 64'h1000_0100_0010_0001, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 64'hFFFF_0000_FFFF_0001, 1'b0);
        idle(2);
        check("fifo drained ready", 128'(sgn_ready), 128'h1);
        check("no underflow yet", 128'(sgn_underflow), 128'h0);
        cyc(1'b0, 4'b0000, 1'b1, 64'h1234, 1'b0);
        idle(1);
        check("underflow set", 128'(sgn_underflow), 128'h1);
        check("underflow no result", 128'(res_valid), 128'h0);
        idle(2);

        // enable freeze holds the pending result
        cyc(1'b1, 4'b0001, 1'b0, 64'h0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 64'h9, 1'b0);
        en = 1'b0;
        idle(2);
        check("freeze res_valid", 128'(res_valid), 128'h0);
        en = 1'b1;
        idle(1);
        check("unfreeze res_valid", 128'(res_valid), 128'h1);
        check("unfreeze seg0", 128'(res_out[31:0]), 128'hFFFF_FFF7);
        idle(2);

        // reset with two products in flight
        cyc(1'b1, 4'b0001, 1'b0, 64'h0, 1'b0);
        cyc(1'b1, 4'b0010, 1'b0, 64'h0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 64'h3, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 64'h4, 1'b0);
        sgn_valid  = 1'b0;
        prod_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        check("midreset res_valid", 128'(res_valid), 128'h0);
        check("midreset res_out", res_out, 128'h0);
        check("midreset underflow", 128'(sgn_underflow), 128'h0);
        check("midreset sgn_ready", 128'(sgn_ready), 128'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(3);
        check("post reset res_valid", 128'(res_valid), 128'h0);

        // back to normal after reset
        cyc(1'b1, 4'b0100, 1'b0, 64'h0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 64'h0000_0002_0000_0000, 1'b0);
        idle(1);
        check("post reset seg2", 128'(res_out[95:64]), 128'hFFFF_FFFE);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
